// File: rtl/instruction_memory_pkg.sv
// ----------------------------------------------------------------------------
// instruction_memory_pkg
//   Shared constants for the IF-stage program memory and its byte loader.
//   BYTE_SIZE       width of one loader byte
//   BYTES_PER_WORD  loader bytes packed into one instruction word
//   INSTR_NOP       word returned for out-of-range fetches (bounds-check build)
// ----------------------------------------------------------------------------
package instruction_memory_pkg;

  localparam int BYTE_SIZE      = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/instruction_memory_byte_assembler.sv
// ----------------------------------------------------------------------------
// byte_assembler
//   Packs a serial byte stream into big-endian words. The first byte of a
//   word ends up in the most significant position.
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_clear       synchronous discard of the partial word
//   i_en          accept i_byte this cycle (caller already gated by full/clear)
//   i_byte        incoming byte
//   o_word        partial bytes + i_byte, valid when o_word_valid is high
//   o_word_valid  combinational: this cycle's byte completes a word
//   o_busy        partial word pending (byte count != 0)
// ----------------------------------------------------------------------------
module byte_assembler
  import instruction_memory_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic [BYTE_SIZE-1:0] i_byte,
  output logic [WORD_SIZE-1:0] o_word,
  output logic                 o_word_valid,
  output logic                 o_busy
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from i_byte so the word can be committed in the same cycle.
  localparam int PART_W = WORD_SIZE - BYTE_SIZE;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [PART_W-1:0] shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;

  always_comb begin
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    o_word_valid = 1'b0;
    o_word       = {shift_q, i_byte};
    if (i_clear) begin
      shift_d    = '0;
      byte_cnt_d = '0;
    end else if (i_en) begin
      if (byte_cnt_q == LAST_BYTE) begin
        o_word_valid = 1'b1;
        shift_d      = '0;
        byte_cnt_d   = '0;
      end else begin
        shift_d    = {shift_q[PART_W-BYTE_SIZE-1:0], i_byte};
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign o_busy = (byte_cnt_q != 2'd0);

endmodule

// File: rtl/instruction_memory.sv
// ----------------------------------------------------------------------------
// instruction_memory
//   IF-stage program memory. Combinational read indexed by the PC; byte-serial
//   write from the debug/loader unit, four bytes per word (big-endian) at an
//   auto-incrementing pointer that saturates at the memory depth.
//   Optional macro IMEM_BOUNDS_CHECK_EN: fetches at or beyond the loaded
//   length return NOP and raise o_fault.
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_clear        sync clear of pointer and partial word (memory kept)
//   i_wr_en        byte write strobe
//   i_wr_byte      byte to load
//   i_pc           byte address from the PC stage
//   o_instruction  word at i_pc[ADDR_W+1:2], combinational
//   o_wr_ack       1-cycle pulse after a word is committed
//   o_wr_err       1-cycle pulse after a write attempt while full
//   o_empty        nothing loaded since reset/clear
//   o_full         write pointer reached the depth
//   o_fault        (IMEM_BOUNDS_CHECK_EN only) fetch outside loaded program
// ----------------------------------------------------------------------------
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int PC_SIZE           = 32,
  parameter int WORD_SIZE         = 32,
  parameter int MEM_SIZE_IN_WORDS = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic [BYTE_SIZE-1:0] i_wr_byte,
  input  logic [PC_SIZE-1:0]   i_pc,
  output logic [WORD_SIZE-1:0] o_instruction,
  output logic                 o_wr_ack,
  output logic                 o_wr_err,
  output logic                 o_empty,
`ifdef IMEM_BOUNDS_CHECK_EN
  output logic                 o_full,
  output logic                 o_fault
`else
  output logic                 o_full
`endif
);

  localparam int ADDR_W = $clog2(MEM_SIZE_IN_WORDS);
  // Pointer carries one extra bit so "full" is distinguishable from "empty".
  localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(MEM_SIZE_IN_WORDS);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE_IN_WORDS];

  logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 wr_err_q, wr_err_d;
  logic                 full;
  logic                 asm_en;
  logic [WORD_SIZE-1:0] asm_word;
  logic                 asm_word_valid;
  logic                 asm_busy;

  assign full = (wr_ptr_q == DEPTH);
  // Clear wins over a simultaneous byte; a full memory drops the byte.
  assign asm_en = i_wr_en && !full && !i_clear;

  byte_assembler #(
    .WORD_SIZE (WORD_SIZE)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .i_en         (asm_en),
    .i_byte       (i_wr_byte),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid),
    .o_busy       (asm_busy)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    if (i_clear) begin
      wr_ptr_d = '0;
    end else if (i_wr_en) begin
      if (full) begin
        wr_err_d = 1'b1;
      end else if (asm_word_valid) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        wr_ack_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Array is deliberately not reset: committed words survive reset/clear.
  always_ff @(posedge i_clk) begin
    if (asm_word_valid) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= asm_word;
    end
  end

  logic [ADDR_W-1:0]    rd_idx;
  logic [WORD_SIZE-1:0] rd_word;

  assign rd_idx  = i_pc[ADDR_W+1:2];
  assign rd_word = mem[rd_idx];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic [PC_SIZE-3:0] pc_word;
  logic               unused_pc;

  // Compare the whole word address so high PC bits cannot alias into range.
  assign pc_word       = i_pc[PC_SIZE-1:2];
  assign o_fault       = (pc_word >= (PC_SIZE-2)'(wr_ptr_q));
  assign o_instruction = o_fault ? WORD_SIZE'(INSTR_NOP) : rd_word;
  assign unused_pc     = ^i_pc[1:0];
`else
  logic unused_pc;

  assign o_instruction = rd_word;
  assign unused_pc     = ^{i_pc[PC_SIZE-1:ADDR_W+2], i_pc[1:0]};
`endif

  assign o_wr_ack = wr_ack_q;
  assign o_wr_err = wr_err_q;
  assign o_full   = full;
  assign o_empty  = (wr_ptr_q == '0) && !asm_busy;

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

  localparam int DEPTH = 64;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [7:0]  i_wr_byte = 8'h00;
  logic [31:0] i_pc = 32'h0;
  logic [31:0] o_instruction;
  logic        o_wr_ack;
  logic        o_wr_err;
  logic        o_empty;
  logic        o_full;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic        o_fault;
`endif

  instruction_memory #(
    .PC_SIZE           (32),
    .WORD_SIZE         (32),
    .MEM_SIZE_IN_WORDS (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_wr_en       (i_wr_en),
    .i_wr_byte     (i_wr_byte),
    .i_pc          (i_pc),
    .o_instruction (o_instruction),
    .o_wr_ack      (o_wr_ack),
    .o_wr_err      (o_wr_err),
    .o_empty       (o_empty),
`ifdef IMEM_BOUNDS_CHECK_EN
    .o_full        (o_full),
    .o_fault       (o_fault)
`else
    .o_full        (o_full)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program image as a list of committed words plus the
  // bytes of the word currently being received.
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  int          m_ptr = 0;
  logic [7:0]  m_part [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".empty"}, 32'(o_empty), 32'(m_ptr == 0 && m_part.size() == 0));
    check({tag, ".full"},  32'(o_full),  32'(m_ptr == DEPTH));
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_part.delete();
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic exp_ack;
    logic exp_err;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (m_ptr == DEPTH) begin
      exp_err = 1'b1;
    end else begin
      m_part.push_back(b);
      if (m_part.size() == 4) begin
        m_mem[m_ptr] = {m_part[0], m_part[1], m_part[2], m_part[3]};
        m_vld[m_ptr] = 1'b1;
        m_ptr++;
        m_part.delete();
        exp_ack = 1'b1;
      end
    end
    i_wr_en   = 1'b1;
    i_wr_byte = b;
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
    check("wr_ack", 32'(o_wr_ack), 32'(exp_ack));
    check("wr_err", 32'(o_wr_err), 32'(exp_err));
    check_flags("wr");
  endtask

  task automatic clear_cycle(input logic with_byte);
    model_reset();
    i_clear   = 1'b1;
    i_wr_en   = with_byte;
    i_wr_byte = 8'($urandom);
    @(posedge i_clk);
    #1;
    i_clear = 1'b0;
    i_wr_en = 1'b0;
    check("clr_ack", 32'(o_wr_ack), 32'h0);
    check("clr_err", 32'(o_wr_err), 32'h0);
    check_flags("clr");
  endtask

  task automatic idle_cycle();
    @(posedge i_clk);
    #1;
    check("idle_ack", 32'(o_wr_ack), 32'h0);
    check("idle_err", 32'(o_wr_err), 32'h0);
  endtask

  // Fetch word idx with the given low address bits and check it against
  // the model. Unwritten words are only checked where a NOP is expected.
  task automatic read_word(input int idx, input logic [1:0] lo);
    logic [31:0] pc;
    bit          fault;
    pc = (32'(idx) << 2) | 32'(lo);
`ifndef IMEM_BOUNDS_CHECK_EN
    pc[31:8] = 24'($urandom);
`endif
    @(negedge i_clk);
    i_pc = pc;
    #1;
`ifdef IMEM_BOUNDS_CHECK_EN
    fault = (idx >= m_ptr);
    check("rd_fault", 32'(o_fault), 32'(fault));
    if (fault) check("rd_nop", o_instruction, 32'h0);
    else       check("rd_word", o_instruction, m_mem[idx]);
`else
    fault = 1'b0;
    if (m_vld[idx]) check("rd_word", o_instruction, m_mem[idx]);
`endif
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    int         idx;

    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;

    // Reset asserted: flags must already be at reset values.
    #2;
    check("rst_empty", 32'(o_empty), 32'h1);
    check("rst_full",  32'(o_full),  32'h0);
    check("rst_ack",   32'(o_wr_ack), 32'h0);
    check("rst_err",   32'(o_wr_err), 32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    idle_cycle();
    check_flags("post_rst");

    // Single word, first byte is MSB.
    write_byte(8'h20);
    write_byte(8'h01);
    write_byte(8'h00);
    write_byte(8'h05);
    idle_cycle();
    @(negedge i_clk);
    i_pc = 32'h0;
    #1;
    check("word0_pc0", o_instruction, 32'h2001_0005);
    i_pc = 32'h2;
    #1;
    check("word0_pc2", o_instruction, 32'h2001_0005);
    check("word0_empty", 32'(o_empty), 32'h0);

    // Fill the whole memory, then overflow by one byte.
    clear_cycle(1'b0);
    for (int i = 0; i < DEPTH * 4; i++) write_byte(8'($urandom));
    check("fill_full", 32'(o_full), 32'h1);
    write_byte(8'($urandom));
    idle_cycle();
    for (int i = 0; i < DEPTH; i++) read_word(i, 2'($urandom));

    // Partial word discarded by clear; clear beats a simultaneous byte.
    clear_cycle(1'b0);
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    clear_cycle(1'b1);
    write_byte(8'hAA);
    write_byte(8'hBB);
    write_byte(8'hCC);
    write_byte(8'hDD);
    @(negedge i_clk);
    i_pc = 32'h0;
    #1;
    check("clr_word0", o_instruction, 32'hAABB_CCDD);
    read_word(0, 2'b11);
    read_word(1, 2'b00);

    // Reset mid-word: partial bytes lost, committed words kept.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    i_reset = 1'b0;
    #1;
    model_reset();
    check("midrst_empty", 32'(o_empty), 32'h1);
    check("midrst_full",  32'(o_full),  32'h0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
`ifndef IMEM_BOUNDS_CHECK_EN
    read_word(0, 2'b00);
    read_word(1, 2'b01);
    read_word(37, 2'b10);
`endif
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    read_word(0, 2'b00);

`ifdef IMEM_BOUNDS_CHECK_EN
    // Bounds check: two words loaded.
    clear_cycle(1'b0);
    for (int i = 0; i < 8; i++) write_byte(8'($urandom));
    @(negedge i_clk);
    i_pc = 32'h4;
    #1;
    check("bc_pc4", o_instruction, m_mem[1]);
    check("bc_pc4_fault", 32'(o_fault), 32'h0);
    i_pc = 32'h8;
    #1;
    check("bc_pc8", o_instruction, 32'h0);
    check("bc_pc8_fault", 32'(o_fault), 32'h1);
    i_pc = 32'h400;
    #1;
    check("bc_pc400", o_instruction, 32'h0);
    check("bc_pc400_fault", 32'(o_fault), 32'h1);
`else
    // Upper PC bits are truncated: 0x404 aliases word 1.
    @(negedge i_clk);
    i_pc = 32'h404;
    #1;
    check("trunc_pc404", o_instruction, m_mem[1]);
`endif

    // Randomized mix of writes, clears and fetches.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        b = 8'($urandom);
        write_byte(b);
      end else if (r < 70) begin
        clear_cycle(1'($urandom));
      end else begin
        idx = $urandom_range(0, DEPTH - 1);
        read_word(idx, 2'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
